// File: rtl/kbd_scan_ctrl.sv
// rtl/kbd_scan_ctrl.sv - Agat-9 keyboard matrix scan sequencer with debounce and strobe/ack handshake
module kbd_scan_ctrl #(
  parameter int DIV = 16,
  parameter int DEB = 3
) (
  input  logic       C,
  input  logic       Rn,
  input  logic       sense_n,
  input  logic       ack,
  output logic [2:0] row_sel,
  output logic [2:0] col_sel,
  output logic       col_en_n,
  output logic [5:0] code,
  output logic       strb
);

  localparam int              DCW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DCW-1:0]  DC_LAST = DCW'(DIV - 1);
  localparam logic [3:0]      SC_DONE = 4'(DEB);

  typedef enum logic [1:0] {
    S_SCAN,
    S_PRESS,
    S_REPORT,
    S_RELEASE
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [DCW-1:0] r_dc;
  logic [5:0]     r_addr;
  logic [5:0]     w_addr_nxt;
  logic [3:0]     r_sc;
  logic [3:0]     w_sc_nxt;
  logic [3:0]     w_sc_inc;
  logic [5:0]     r_code;
  logic [5:0]     w_code_nxt;
  logic           r_col_en_n;
  logic           w_tick;

  assign w_tick   = (r_dc == DC_LAST);
  assign w_sc_inc = r_sc + 4'd1;

  // Dwell counter free-runs in every state; sense_n is only trusted on its last cycle.
  always_ff @(posedge C) begin
    if (!Rn) begin
      r_dc <= '0;
    end else if (w_tick) begin
      r_dc <= '0;
    end else begin
      r_dc <= r_dc + DCW'(1);
    end
  end

  always_ff @(posedge C) begin
    if (!Rn) begin
      r_state    <= S_SCAN;
      r_addr     <= 6'd0;
      r_sc       <= 4'd0;
      r_code     <= 6'd0;
      r_col_en_n <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_sc       <= w_sc_nxt;
      r_code     <= w_code_nxt;
      r_col_en_n <= 1'b0;
    end
  end

  // Every transition clears sc so each state starts its stability count from zero.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_sc_nxt    = r_sc;
    w_code_nxt  = r_code;
    case (r_state)
      S_SCAN: begin
        if (w_tick) begin
          if (!sense_n) begin
            w_state_nxt = S_PRESS;
            w_sc_nxt    = 4'd0;
          end else begin
            w_addr_nxt = r_addr + 6'd1;
          end
        end
      end
      S_PRESS: begin
        if (w_tick) begin
          if (!sense_n) begin
            if (w_sc_inc == SC_DONE) begin
              w_state_nxt = S_REPORT;
              w_code_nxt  = r_addr;
              w_sc_nxt    = 4'd0;
            end else begin
              w_sc_nxt = w_sc_inc;
            end
          end else begin
            w_state_nxt = S_SCAN;
            w_addr_nxt  = r_addr + 6'd1;
            w_sc_nxt    = 4'd0;
          end
        end
      end
      S_REPORT: begin
        if (ack) begin
          w_state_nxt = S_RELEASE;
          w_sc_nxt    = 4'd0;
        end
      end
      S_RELEASE: begin
        if (w_tick) begin
          if (sense_n) begin
            if (w_sc_inc == SC_DONE) begin
              w_state_nxt = S_SCAN;
              w_addr_nxt  = r_addr + 6'd1;
              w_sc_nxt    = 4'd0;
            end else begin
              w_sc_nxt = w_sc_inc;
            end
          end else begin
            w_sc_nxt = 4'd0;
          end
        end
      end
      default: begin
        w_state_nxt = S_SCAN;
        w_sc_nxt    = 4'd0;
      end
    endcase
  end

  assign row_sel  = r_addr[5:3];
  assign col_sel  = r_addr[2:0];
  assign col_en_n = r_col_en_n;
  assign code     = r_code;
  assign strb     = (r_state == S_REPORT);

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// tb/tb_kbd_scan_ctrl.sv - scoreboard bench for kbd_scan_ctrl with a modelled key matrix
module tb_kbd_scan_ctrl;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic        C = 1'b0;
  logic        Rn = 1'b0;
  logic        ack = 1'b0;
  logic        sense_n;
  logic [2:0]  row_sel;
  logic [2:0]  col_sel;
  logic        col_en_n;
  logic [5:0]  code;
  logic        strb;
  logic [5:0]  addr;
  logic [63:0] keys = '0;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int base = 0;
  int n_reports = 0;
  logic strb_q = 1'b0;
  logic [5:0] exp_q[$];

  kbd_scan_ctrl #(.DIV(DIV), .DEB(DEB)) dut (
    .C        (C),
    .Rn       (Rn),
    .sense_n  (sense_n),
    .ack      (ack),
    .row_sel  (row_sel),
    .col_sel  (col_sel),
    .col_en_n (col_en_n),
    .code     (code),
    .strb     (strb)
  );

  always #5 C = ~C;

  assign addr    = {row_sel, col_sel};
  assign sense_n = ~keys[addr];

  always @(posedge C) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard monitor: each strb rising edge consumes one expected code.
  always @(negedge C) begin
    if (strb === 1'b1 && strb_q !== 1'b1) begin
      n_reports++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strb: got strb with code 0x%0h, expected no report", code);
      end else begin
        check("report_code", int'(code), int'(exp_q.pop_front()));
      end
    end
    strb_q <= strb;
  end

  task automatic step(input int k);
    repeat (k) @(negedge C);
  endtask

  task automatic goto_rel(input int target);
    while (cyc - base < target) @(negedge C);
  endtask

  task automatic do_reset();
    Rn = 1'b0;
    @(posedge C);
    @(negedge C);
    Rn = 1'b1;
    base = cyc;
  endtask

  task automatic wait_strb(input string name, input int bound, output int rel, output bit ok);
    ok  = 1'b0;
    rel = -1;
    for (int i = 0; i < bound; i++) begin
      if (strb === 1'b1) begin
        ok  = 1'b1;
        rel = cyc - base;
        break;
      end
      @(negedge C);
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no strb within %0d cycles, expected strb", name, bound);
    end
  endtask

  initial begin
    int  errs;
    int  rel;
    int  a255;
    int  a256;
    int  key;
    int  rep0;
    bit  ok;

    Rn = 1'b0;
    repeat (2) @(posedge C);
    @(negedge C);
    check("reset_strb", int'(strb), 0);
    check("reset_code", int'(code), 0);
    check("reset_col_en_n", int'(col_en_n), 1);
    check("reset_addr", int'(addr), 0);
    Rn = 1'b1;
    base = cyc;
    step(1);
    check("col_en_after_reset", int'(col_en_n), 0);

    // Unpressed sweep: addr = rel/DIV mod 64, full wrap after 64*DIV cycles.
    errs = 0;
    a255 = -1;
    a256 = -1;
    for (int r = 2; r <= 257; r++) begin
      step(1);
      if (int'(addr) != (r / DIV) % 64) errs++;
      if (r == 255) a255 = int'(addr);
      if (r == 256) a256 = int'(addr);
    end
    check("sweep_addr_seq", errs, 0);
    check("sweep_addr_63", a255, 63);
    check("sweep_wrap_256", a256, 0);

    // Key 0x2A: detected at rel 172, confirmed at 176/180/184.
    do_reset();
    keys[42] = 1'b1;
    exp_q.push_back(6'h2A);
    wait_strb("press_wait", 400, rel, ok);
    check("press_latency", rel, 172 + DEB * DIV);
    check("press_addr_frozen", int'(addr), 42);
    check("col_en_in_report", int'(col_en_n), 0);
    errs = 0;
    repeat (100) begin
      step(1);
      if (strb !== 1'b1) errs++;
    end
    check("strb_hold_no_ack", errs, 0);
    goto_rel(284);
    ack = 1'b1;
    step(1);
    check("strb_drop_after_ack", int'(strb), 0);
    ack = 1'b0;
    goto_rel(485);
    check("addr_frozen_while_held", int'(addr), 42);
    keys[42] = 1'b0;
    goto_rel(495);
    check("release_not_early", int'(addr), 42);
    step(1);
    check("release_resume_2b", int'(addr), 43);

    // Bounce at 0x15: one low tick then high.
    do_reset();
    keys[21] = 1'b1;
    goto_rel(88);
    check("bounce_addr_frozen", int'(addr), 21);
    keys[21] = 1'b0;
    goto_rel(91);
    check("bounce_hold_before_tick", int'(addr), 21);
    step(1);
    check("bounce_resume_16", int'(addr), 22);
    check("bounce_no_strb", int'(strb), 0);
    goto_rel(96);
    check("bounce_scan_continues", int'(addr), 23);

    // Two keys with ack tied high: round-robin 0x05, 0x30.
    do_reset();
    ack = 1'b1;
    keys[5]  = 1'b1;
    keys[48] = 1'b1;
    rep0 = n_reports;
    exp_q.push_back(6'h05);
    exp_q.push_back(6'h30);
    exp_q.push_back(6'h05);
    exp_q.push_back(6'h30);
    for (int k = 0; k < 4; k++) begin
      key = (k % 2 == 0) ? 5 : 48;
      wait_strb("rr_wait", 2000, rel, ok);
      if (!ok) break;
      step(1);
      check("rr_strb_one_cycle", int'(strb), 0);
      keys[key] = 1'b0;
      for (int i = 0; i < 100 && int'(addr) == key; i++) step(1);
      check("rr_resume_next", int'(addr), (key + 1) % 64);
      keys[key] = 1'b1;
    end
    check("rr_report_count", n_reports - rep0, 4);
    ack = 1'b0;
    keys = '0;

    // Reset pulse during REPORT.
    do_reset();
    keys[42] = 1'b1;
    exp_q.push_back(6'h2A);
    wait_strb("rst_press_wait", 400, rel, ok);
    Rn = 1'b0;
    step(1);
    check("rst_strb", int'(strb), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_code", int'(code), 0);
    check("rst_col_en_n", int'(col_en_n), 1);
    Rn = 1'b1;
    base = cyc;
    keys = '0;
    step(1);
    check("rst_col_en_back", int'(col_en_n), 0);
    goto_rel(3);
    check("rst_addr_hold0", int'(addr), 0);
    goto_rel(4);
    check("rst_restart_scan", int'(addr), 1);

    step(2);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
